// File: rtl/apb_spi_master_bridge_if.sv
// APB3 bus bundle for the SPI master bridge.
// The slave modport is the bridge side; the master modport is the bus/initiator side.
interface apb_spi_master_bridge_if #(
  parameter int ADDR_W = 4
);
  logic              psel_i;
  logic              penable_i;
  logic              pwrite_i;
  logic [ADDR_W-1:0] paddr_bi;
  logic [31:0]       pwdata_bi;
  logic [31:0]       prdata_bo;
  logic              pready_o;
  logic              pslverr_o;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_bi, pwdata_bi,
    output prdata_bo, pready_o, pslverr_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_bi, pwdata_bi,
    input  prdata_bo, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_spi_master_bridge.sv
// APB3 slave front-end for spi_master_driver.
// Software pushes bytes into a TX FIFO; a small sequencer launches one driver
// transfer per byte and stores each received byte into an RX FIFO that
// software drains by polling (or via the level interrupt).

// Simple synchronous FIFO; the caller guarantees push only when there is room
// (or a same-cycle pop) and pop only when not empty.
module apb_spi_master_bridge_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;

  assign empty = (count_r == {(PTR_W + 1){1'b0}});
  assign full  = (count_r == CNT_FULL);
  assign rdata = mem_r[rd_ptr_r];

  // Storage array: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally (power-of-two depth); the count tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

module apb_spi_master_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  apb_spi_master_bridge_if.slave      apb,
  output logic                        drv_start_o,
  output logic [7:0]                  drv_data_bo,
  input  logic                        drv_busy_i,
  input  logic [7:0]                  drv_data_bi,
  output logic                        irq_o
);
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_XFER      = 3'd3,
    ST_STORE     = 3'd4
  } seq_state_t;

  seq_state_t  state_r;
  logic        drv_start_r;
  logic [7:0]  drv_data_r;
  logic [7:0]  rx_byte_r;
  logic [1:0]  wait_cnt_r;
  logic        enable_r;
  logic        irq_en_r;
  logic        rx_ovf_r;
  logic        irq_r;

  logic [ADDR_W-1:0] paddr_s;
  logic [1:0]  reg_sel_s;
  logic        access_s;
  logic        data_wr_s;
  logic        ctrl_wr_s;
  logic        tx_push_s;
  logic        tx_pop_s;
  logic        rx_push_s;
  logic        rx_pop_s;
  logic        ovf_set_s;
  logic        tx_empty_s;
  logic        tx_full_s;
  logic        rx_empty_s;
  logic        rx_full_s;
  logic [7:0]  tx_head_s;
  logic [7:0]  rx_head_s;
  logic        seq_busy_s;
  logic [31:0] status_s;
  logic [31:0] prdata_s;
  logic        pslverr_s;
  logic        unused_bits_s;

  assign paddr_s       = apb.paddr_bi;
  assign reg_sel_s     = paddr_s[3:2];
  assign unused_bits_s = ^{apb.pwdata_bi, paddr_s};
  assign access_s      = apb.psel_i & apb.penable_i;

  assign data_wr_s = access_s & apb.pwrite_i & (reg_sel_s == 2'd0);
  assign ctrl_wr_s = access_s & apb.pwrite_i & (reg_sel_s == 2'd2);
  assign rx_pop_s  = access_s & ~apb.pwrite_i & (reg_sel_s == 2'd0) & ~rx_empty_s;

  // The sequencer pops the TX head in IDLE; a full FIFO still accepts a
  // write in the cycle the sequencer frees a slot.
  assign tx_pop_s  = (state_r == ST_IDLE) & enable_r & ~tx_empty_s;
  assign tx_push_s = data_wr_s & (~tx_full_s | tx_pop_s);

  assign rx_push_s = (state_r == ST_STORE) & (~rx_full_s | rx_pop_s);
  assign ovf_set_s = (state_r == ST_STORE) & rx_full_s & ~rx_pop_s;

  assign seq_busy_s = (state_r != ST_IDLE);
  assign status_s   = {26'd0, rx_ovf_r, seq_busy_s, rx_full_s, rx_empty_s,
                       tx_full_s, tx_empty_s};

  apb_spi_master_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .wdata (apb.pwdata_bi[7:0]),
    .rdata (tx_head_s),
    .empty (tx_empty_s),
    .full  (tx_full_s)
  );

  apb_spi_master_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .wdata (rx_byte_r),
    .rdata (rx_head_s),
    .empty (rx_empty_s),
    .full  (rx_full_s)
  );

  // Read mux and error decode; both are only meaningful in the access phase.
  always_comb begin
    prdata_s  = 32'd0;
    pslverr_s = 1'b0;
    if (access_s) begin
      case (reg_sel_s)
        2'd0: begin
          if (apb.pwrite_i) begin
            pslverr_s = tx_full_s & ~tx_pop_s;
          end else begin
            prdata_s = rx_empty_s ? 32'd0 : {24'd0, rx_head_s};
          end
        end
        2'd1: begin
          prdata_s = apb.pwrite_i ? 32'd0 : status_s;
        end
        2'd2: begin
          prdata_s = apb.pwrite_i ? 32'd0 : {30'd0, irq_en_r, enable_r};
        end
        default: begin
          pslverr_s = apb.pwrite_i;
        end
      endcase
    end else begin
      prdata_s  = 32'd0;
      pslverr_s = 1'b0;
    end
  end

  assign apb.prdata_bo = prdata_s;
  assign apb.pslverr_o = pslverr_s;
  assign apb.pready_o  = 1'b1;

  // CTRL register and sticky overflow; a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      enable_r <= 1'b0;
      irq_en_r <= 1'b0;
      rx_ovf_r <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        enable_r <= apb.pwdata_bi[0];
        irq_en_r <= apb.pwdata_bi[1];
      end
      if (ovf_set_s) begin
        rx_ovf_r <= 1'b1;
      end else if (ctrl_wr_s && apb.pwdata_bi[2]) begin
        rx_ovf_r <= 1'b0;
      end
    end
  end

  // Level interrupt, registered for a clean output.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_en_r & (~rx_empty_s | rx_ovf_r);
    end
  end

  // Transfer sequencer: pop, pulse start, wait for busy, capture, store.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      drv_start_r <= 1'b0;
      drv_data_r  <= 8'd0;
      rx_byte_r   <= 8'd0;
      wait_cnt_r  <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (tx_pop_s) begin
            drv_data_r  <= tx_head_s;
            drv_start_r <= 1'b1;
            state_r     <= ST_START;
          end else begin
            drv_start_r <= 1'b0;
          end
        end
        ST_START: begin
          drv_start_r <= 1'b0;
          wait_cnt_r  <= 2'd0;
          state_r     <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A driver that never answers must not hang the sequencer.
          if (drv_busy_i) begin
            state_r <= ST_XFER;
          end else if (wait_cnt_r == 2'd3) begin
            state_r <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        ST_XFER: begin
          if (!drv_busy_i) begin
            rx_byte_r <= drv_data_bi;
            state_r   <= ST_STORE;
          end
        end
        ST_STORE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          drv_start_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign drv_start_o = drv_start_r;
  assign drv_data_bo = drv_data_r;
  assign irq_o       = irq_r;
endmodule

// File: tb/tb_apb_spi_master_bridge.sv
// Directed bench for apb_spi_master_bridge with a behavioural SPI driver model.
module tb_apb_spi_master_bridge;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drv_start;
  logic [7:0] drv_data_out;
  logic       drv_busy;
  logic [7:0] drv_data_in;
  logic       irq;

  int checks = 0;
  int errors = 0;

  // Driver model controls and log of bytes seen at each start pulse.
  logic       slave_on = 1'b1;
  logic       resp_mode = 1'b0;
  logic [1:0] bcnt;
  int         start_cnt = 0;
  logic [7:0] sent_log [64];

  apb_spi_master_bridge_if #(.ADDR_W(4)) apb ();

  apb_spi_master_bridge #(.FIFO_DEPTH(4), .ADDR_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .apb         (apb.slave),
    .drv_start_o (drv_start),
    .drv_data_bo (drv_data_out),
    .drv_busy_i  (drv_busy),
    .drv_data_bi (drv_data_in),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  assign drv_data_in = resp_mode ? ~drv_data_out : 8'hA5;

  // Driver model: busy for 4 cycles after an accepted start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_busy <= 1'b0;
      bcnt     <= 2'd0;
    end else if (drv_start && slave_on && !drv_busy) begin
      drv_busy <= 1'b1;
      bcnt     <= 2'd3;
    end else if (drv_busy) begin
      if (bcnt == 2'd0) drv_busy <= 1'b0;
      else bcnt <= bcnt - 2'd1;
    end
  end

  // Log every start pulse and the byte presented with it.
  always @(posedge clk) begin
    if (drv_start) begin
      sent_log[start_cnt[5:0]] <= drv_data_out;
      start_cnt <= start_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
    apb.paddr_bi = addr; apb.pwdata_bi = data;
    @(negedge clk);
    apb.penable_i = 1'b1;
    #1 err = apb.pslverr_o;
    @(negedge clk);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0; apb.paddr_bi = addr;
    @(negedge clk);
    apb.penable_i = 1'b1;
    #1 begin data = apb.prdata_bo; err = apb.pslverr_o; end
    @(negedge clk);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
  endtask

  // Poll STATUS until it equals exp or the budget expires; the final value is checked.
  task automatic poll_status(input string tag, input logic [31:0] exp);
    logic [31:0] st;
    logic        e;
    st = 32'd0;
    for (int i = 0; i < 60; i++) begin
      apb_read(4'h4, st, e);
      if (st == exp) break;
    end
    check(tag, st, exp);
  endtask

  logic [31:0] rd;
  logic        err;
  int          base;

  initial begin
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.paddr_bi = 4'h0; apb.pwdata_bi = 32'd0;

    // Reset state
    #23;
    check("rst_start", {31'd0, drv_start}, 32'd0);
    check("rst_data", {24'd0, drv_data_out}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_pready", {31'd0, apb.pready_o}, 32'd1);
    check("rst_pslverr", {31'd0, apb.pslverr_o}, 32'd0);
    check("rst_prdata", apb.prdata_bo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    apb_read(4'h4, rd, err);
    check("status_after_rst", rd, 32'h05);

    // Single loopback transfer
    base = start_cnt;
    apb_write(4'h0, 32'hAC, err);
    check("wr_data_err", {31'd0, err}, 32'd0);
    apb_write(4'h8, 32'h1, err);
    poll_status("t1_status_done", 32'h01);
    check("t1_starts", start_cnt - base, 32'd1);
    check("t1_sent", {24'd0, sent_log[base[5:0]]}, 32'hAC);
    check("t1_drv_data_hold", {24'd0, drv_data_out}, 32'hAC);
    apb_read(4'h0, rd, err);
    check("t1_rx_byte", rd, 32'h000000A5);
    apb_read(4'h4, rd, err);
    check("t1_status_empty", rd, 32'h05);

    // TX fill with the sequencer disabled
    apb_write(4'h8, 32'h0, err);
    apb_write(4'h0, 32'h11, err);
    apb_write(4'h0, 32'h22, err);
    apb_write(4'h0, 32'h33, err);
    apb_write(4'h0, 32'h44, err);
    check("tx_4th_err", {31'd0, err}, 32'd0);
    apb_write(4'h0, 32'h55, err);
    check("tx_5th_err", {31'd0, err}, 32'd1);
    apb_read(4'h4, rd, err);
    check("tx_full_status", rd, 32'h06);

    // Drain TX into RX (no reads), inverted responses, irq enabled
    resp_mode = 1'b1;
    base = start_cnt;
    apb_write(4'h8, 32'h3, err);
    poll_status("rx_full_status", 32'h09);
    check("order0", {24'd0, sent_log[base[5:0]]}, 32'h11);
    check("order1", {24'd0, sent_log[base[5:0] + 6'd1]}, 32'h22);
    check("order2", {24'd0, sent_log[base[5:0] + 6'd2]}, 32'h33);
    check("order3", {24'd0, sent_log[base[5:0] + 6'd3]}, 32'h44);
    check("irq_set", {31'd0, irq}, 32'd1);
    apb_write(4'h0, 32'h66, err);
    poll_status("ovf_status", 32'h29);
    check("ovf_sent", {24'd0, sent_log[base[5:0] + 6'd4]}, 32'h66);
    check("ovf_starts", start_cnt - base, 32'd5);
    apb_write(4'h8, 32'h7, err);
    apb_read(4'h4, rd, err);
    check("ovf_cleared", rd, 32'h09);
    apb_read(4'h8, rd, err);
    check("ctrl_readback", rd, 32'h3);
    apb_read(4'h0, rd, err);
    check("rx0", rd, 32'hEE);
    apb_read(4'h0, rd, err);
    check("rx1", rd, 32'hDD);
    apb_read(4'h0, rd, err);
    check("rx2", rd, 32'hCC);
    apb_read(4'h0, rd, err);
    check("rx3", rd, 32'hBB);
    apb_read(4'h4, rd, err);
    check("rx_drained", rd, 32'h05);
    @(negedge clk);
    check("irq_clear", {31'd0, irq}, 32'd0);

    // Empty RX read and reserved address
    apb_read(4'h0, rd, err);
    check("rx_empty_rd", rd, 32'd0);
    check("rx_empty_err", {31'd0, err}, 32'd0);
    apb_read(4'hC, rd, err);
    check("rsvd_rd", rd, 32'd0);
    check("rsvd_rd_err", {31'd0, err}, 32'd0);
    apb_write(4'hC, 32'hFFFF_FFFF, err);
    check("rsvd_wr_err", {31'd0, err}, 32'd1);
    apb_read(4'h4, rd, err);
    check("status_unchanged", rd, 32'h05);

    // Driver never asserts busy: timeout, byte discarded
    slave_on = 1'b0;
    base = start_cnt;
    apb_write(4'h0, 32'h5A, err);
    apb_read(4'h4, rd, err);
    check("to_seq_busy", rd, 32'h15);
    repeat (10) @(negedge clk);
    apb_read(4'h4, rd, err);
    check("to_status", rd, 32'h05);
    check("to_starts", start_cnt - base, 32'd1);

    // Reset in the middle of a transfer
    slave_on = 1'b1;
    resp_mode = 1'b0;
    apb_write(4'h8, 32'h1, err);
    apb_write(4'h0, 32'h3C, err);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (drv_busy) break;
    end
    check("busy_seen", {31'd0, drv_busy}, 32'd1);
    @(negedge clk);
    check("pre_rst_data", {24'd0, drv_data_out}, 32'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data", {24'd0, drv_data_out}, 32'd0);
    check("midrst_start", {31'd0, drv_start}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_pready", {31'd0, apb.pready_o}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    base = start_cnt;
    apb_read(4'h4, rd, err);
    check("post_rst_status", rd, 32'h05);
    apb_read(4'h8, rd, err);
    check("post_rst_ctrl", rd, 32'd0);
    repeat (10) @(negedge clk);
    check("post_rst_no_start", start_cnt - base, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
